// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_ctrl
//  Brief    : Run-control / debug unit for a 6502 core. Provides halt, free-run,
//             divided slow-run, cycle-step and instruction-step modes, address
//             breakpoints and cycle/instruction counters.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DIV_W  = 26,
    parameter int NUM_BP = 2,
    parameter int CNT_W  = 32
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [1:0]               MODE,
    input  logic [DIV_W-1:0]         DIV_VAL,
    input  logic                     STEP_BTN,
    input  logic                     STEP_INSTR,
    input  logic                     RESUME,
    input  logic                     CLR_CNT,
    input  logic                     SYNC,
    input  logic [ADDR_W-1:0]        ADDR,
    input  logic [NUM_BP*ADDR_W-1:0] BP_ADDR,
    input  logic [NUM_BP-1:0]        BP_EN,
    output logic                     CPU_EN,
    output logic [2:0]               STATE,
    output logic [2:0]               BP_ID,
    output logic [CNT_W-1:0]         CYCLE_CNT,
    output logic [CNT_W-1:0]         INSTR_CNT
);

    localparam logic [1:0] c_MODE_HALT = 2'b00;
    localparam logic [1:0] c_MODE_FREE = 2'b01;
    localparam logic [1:0] c_MODE_SLOW = 2'b10;
    localparam logic [1:0] c_MODE_STEP = 2'b11;

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_ISTEP = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_step_meta;
    logic             r_step_sync;
    logic             r_step_dly;
    logic             r_step_pulse;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_skip_bp;
    logic [2:0]       r_bp_id;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    logic             w_bp_match;
    logic [2:0]       w_bp_idx;
    logic             w_bp_hit;
    logic             w_bp_armed;
    logic             w_bp_block;
    logic             w_mode_run;
    logic             w_div_tick;
    logic             w_req;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_bp_match = 1'b0;
        w_bp_idx   = 3'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (BP_EN[i] && (ADDR == BP_ADDR[i*ADDR_W +: ADDR_W])) begin
                w_bp_match = 1'b1;
                w_bp_idx   = 3'(i);
            end
        end
    end

    assign w_bp_hit   = SYNC & w_bp_match;
    assign w_bp_armed = (r_state == S_RUN) || (r_state == S_ISTEP);
    assign w_bp_block = w_bp_hit & ~r_skip_bp & w_bp_armed;
    assign w_mode_run = (MODE == c_MODE_FREE) || (MODE == c_MODE_SLOW);
    assign w_div_tick = (r_div_cnt >= DIV_VAL);

    always_comb begin
        w_req = 1'b0;
        unique case (r_state)
            S_RUN:   w_req = (MODE == c_MODE_FREE) || ((MODE == c_MODE_SLOW) && w_div_tick);
            S_STEP:  w_req = r_step_pulse;
            S_ISTEP: w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    // An instruction step stops on the next opcode fetch without executing it.
    assign CPU_EN    = w_req & ~w_bp_block & ~((r_state == S_ISTEP) & SYNC);
    assign STATE     = r_state;
    assign BP_ID     = r_bp_id;
    assign CYCLE_CNT = r_cycle_cnt;
    assign INSTR_CNT = r_instr_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_step_meta  <= 1'b0;
            r_step_sync  <= 1'b0;
            r_step_dly   <= 1'b0;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_meta  <= STEP_BTN;
            r_step_sync  <= r_step_meta;
            r_step_dly   <= r_step_sync;
            r_step_pulse <= r_step_sync & ~r_step_dly;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div_cnt <= '0;
        end else if ((r_state == S_RUN) && (MODE == c_MODE_SLOW)) begin
            r_div_cnt <= w_div_tick ? '0 : r_div_cnt + DIV_W'(1);
        end else begin
            r_div_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_HALT;
            r_bp_id   <= 3'd0;
            r_skip_bp <= 1'b0;
        end else begin
            if (CPU_EN) begin
                r_skip_bp <= 1'b0;
            end
            if (MODE == c_MODE_HALT) begin
                r_state <= S_HALT;
            end else begin
                unique case (r_state)
                    S_HALT: begin
                        r_state <= (MODE == c_MODE_STEP) ? S_STEP : S_RUN;
                    end
                    S_RUN: begin
                        if (w_bp_block) begin
                            r_state <= S_BREAK;
                            r_bp_id <= w_bp_idx;
                        end else if (MODE == c_MODE_STEP) begin
                            r_state <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        if (r_step_pulse && STEP_INSTR) begin
                            r_state <= S_ISTEP;
                        end else if (w_mode_run) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_ISTEP: begin
                        if (w_bp_block) begin
                            r_state <= S_BREAK;
                            r_bp_id <= w_bp_idx;
                        end else if (SYNC) begin
                            r_state <= S_STEP;
                        end else if (w_mode_run) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_BREAK: begin
                        // Skip lets the stalled breakpoint fetch execute once.
                        if (RESUME) begin
                            r_state   <= w_mode_run ? S_RUN : S_STEP;
                            r_skip_bp <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_HALT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else if (CLR_CNT) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else if (CPU_EN) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (SYNC) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_run_ctrl
//  Brief    : Self-checking bench for cpu_run_ctrl: directed scenarios followed
//             by randomized stimulus, compared each cycle to a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int ADDR_W = 16;
    localparam int DIV_W  = 26;
    localparam int NUM_BP = 2;
    localparam int CNT_W  = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    localparam int ST_HALT  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_STEP  = 2;
    localparam int ST_ISTEP = 3;
    localparam int ST_BREAK = 4;

    logic                     CLK = 1'b0;
    logic                     RESET_N;
    logic [1:0]               MODE;
    logic [DIV_W-1:0]         DIV_VAL;
    logic                     STEP_BTN;
    logic                     STEP_INSTR;
    logic                     RESUME;
    logic                     CLR_CNT;
    logic                     SYNC;
    logic [ADDR_W-1:0]        ADDR;
    logic [NUM_BP*ADDR_W-1:0] BP_ADDR;
    logic [NUM_BP-1:0]        BP_EN;
    logic                     CPU_EN;
    logic [2:0]               STATE;
    logic [2:0]               BP_ID;
    logic [CNT_W-1:0]         CYCLE_CNT;
    logic [CNT_W-1:0]         INSTR_CNT;

    cpu_run_ctrl #(
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W),
        .NUM_BP (NUM_BP),
        .CNT_W  (CNT_W)
    ) u_dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .MODE       (MODE),
        .DIV_VAL    (DIV_VAL),
        .STEP_BTN   (STEP_BTN),
        .STEP_INSTR (STEP_INSTR),
        .RESUME     (RESUME),
        .CLR_CNT    (CLR_CNT),
        .SYNC       (SYNC),
        .ADDR       (ADDR),
        .BP_ADDR    (BP_ADDR),
        .BP_EN      (BP_EN),
        .CPU_EN     (CPU_EN),
        .STATE      (STATE),
        .BP_ID      (BP_ID),
        .CYCLE_CNT  (CYCLE_CNT),
        .INSTR_CNT  (INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: run mode, cycles waited in slow-run, resume flag,
    // last break id, counters, and the button as seen in previous cycles.
    int m_state;
    int m_wait;
    bit m_skip;
    int m_bpid;
    int m_cyc;
    int m_instr;
    bit btn_ago [1:4];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = ST_HALT;
        m_wait  = 0;
        m_skip  = 1'b0;
        m_bpid  = 0;
        m_cyc   = 0;
        m_instr = 0;
        for (int k = 1; k <= 4; k++) btn_ago[k] = 1'b0;
    endtask

    // Compares at the falling edge, advances the model, returns just after the next rising edge.
    task automatic do_cycle();
        bit  hit;
        int  idx;
        bit  pulse;
        bit  run_mode;
        bit  armed;
        bit  blocked;
        bit  req;
        bit  en;
        bit  set_skip;
        int  mode;
        int  nxt;
        @(negedge CLK);
        if (!RESET_N) model_reset();
        mode     = int'(MODE);
        run_mode = (mode == 1) || (mode == 2);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (!hit && SYNC && BP_EN[i] && (ADDR == BP_ADDR[i*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = i;
            end
        end
        pulse   = btn_ago[3] && !btn_ago[4];
        armed   = (m_state == ST_RUN) || (m_state == ST_ISTEP);
        blocked = hit && !m_skip && armed;
        case (m_state)
            ST_RUN:   req = (mode == 1) || ((mode == 2) && (m_wait >= int'(DIV_VAL)));
            ST_STEP:  req = pulse;
            ST_ISTEP: req = 1'b1;
            default:  req = 1'b0;
        endcase
        en = req && !blocked && !((m_state == ST_ISTEP) && SYNC);

        check_val("cpu_en",    64'(CPU_EN),    64'(en));
        check_val("state",     64'(STATE),     64'(m_state));
        check_val("bp_id",     64'(BP_ID),     64'(m_bpid));
        check_val("cycle_cnt", 64'(CYCLE_CNT), 64'(m_cyc));
        check_val("instr_cnt", 64'(INSTR_CNT), 64'(m_instr));

        if (!RESET_N) begin
            model_reset();
        end else begin
            if (CLR_CNT) begin
                m_cyc   = 0;
                m_instr = 0;
            end else if (en) begin
                m_cyc = (m_cyc + 1) % CNT_MOD;
                if (SYNC) m_instr = (m_instr + 1) % CNT_MOD;
            end
            if ((m_state == ST_RUN) && (mode == 2))
                m_wait = (m_wait >= int'(DIV_VAL)) ? 0 : m_wait + 1;
            else
                m_wait = 0;
            set_skip = 1'b0;
            nxt = m_state;
            if (mode == 0) begin
                nxt = ST_HALT;
            end else if (m_state == ST_HALT) begin
                nxt = (mode == 3) ? ST_STEP : ST_RUN;
            end else if (m_state == ST_RUN) begin
                if (blocked) begin
                    nxt = ST_BREAK;
                    m_bpid = idx;
                end else if (mode == 3) begin
                    nxt = ST_STEP;
                end
            end else if (m_state == ST_STEP) begin
                if (pulse && STEP_INSTR) nxt = ST_ISTEP;
                else if (run_mode)       nxt = ST_RUN;
            end else if (m_state == ST_ISTEP) begin
                if (blocked) begin
                    nxt = ST_BREAK;
                    m_bpid = idx;
                end else if (SYNC) begin
                    nxt = ST_STEP;
                end else if (run_mode) begin
                    nxt = ST_RUN;
                end
            end else if (m_state == ST_BREAK) begin
                if (RESUME) begin
                    nxt = run_mode ? ST_RUN : ST_STEP;
                    set_skip = 1'b1;
                end
            end
            if (set_skip)  m_skip = 1'b1;
            else if (en)   m_skip = 1'b0;
            m_state = nxt;
            btn_ago[4] = btn_ago[3];
            btn_ago[3] = btn_ago[2];
            btn_ago[2] = btn_ago[1];
            btn_ago[1] = STEP_BTN;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) do_cycle();
    endtask

    initial begin
        RESET_N    = 1'b0;
        MODE       = 2'b00;
        DIV_VAL    = '0;
        STEP_BTN   = 1'b0;
        STEP_INSTR = 1'b0;
        RESUME     = 1'b0;
        CLR_CNT    = 1'b0;
        SYNC       = 1'b0;
        ADDR       = 16'h0000;
        BP_ADDR    = {16'hC000, 16'h1234};
        BP_EN      = 2'b00;
        model_reset();
        @(posedge CLK);
        #1;
        run_cycles(3);

        // Free run
        RESET_N = 1'b1;
        MODE    = 2'b01;
        run_cycles(11);
        check_val("free_cycles", 64'(CYCLE_CNT), 64'd10);
        check_val("free_instr",  64'(INSTR_CNT), 64'd0);

        // Slow run, then divider lowered to zero mid-count
        MODE    = 2'b10;
        DIV_VAL = DIV_W'(3);
        run_cycles(40);
        DIV_VAL = '0;
        run_cycles(6);

        // Cycle step, button held high afterwards
        MODE       = 2'b11;
        STEP_INSTR = 1'b0;
        run_cycles(3);
        STEP_BTN = 1'b1;
        run_cycles(10);
        STEP_BTN = 1'b0;
        run_cycles(3);

        // Instruction step with SYNC pattern 1,0,0,1 after the pulse
        STEP_INSTR = 1'b1;
        STEP_BTN   = 1'b1;
        run_cycles(3);
        SYNC = 1'b1; do_cycle();
        SYNC = 1'b0; do_cycle();
        do_cycle();
        SYNC = 1'b1; do_cycle();
        SYNC = 1'b0;
        check_val("istep_back", 64'(STATE), 64'(ST_STEP));
        STEP_BTN = 1'b0;
        run_cycles(3);

        // Breakpoint 1 at C000, then resume
        MODE  = 2'b01;
        BP_EN = 2'b10;
        ADDR  = 16'h0100;
        run_cycles(3);
        ADDR = 16'hC000;
        SYNC = 1'b1;
        do_cycle();
        check_val("bp_state", 64'(STATE), 64'(ST_BREAK));
        check_val("bp_id1",   64'(BP_ID), 64'd1);
        run_cycles(2);
        RESUME = 1'b1; do_cycle();
        RESUME = 1'b0; do_cycle();
        check_val("resume_state", 64'(STATE), 64'(ST_RUN));
        ADDR = 16'hC003;
        SYNC = 1'b0;
        run_cycles(3);

        // Counter wrap and clear against increment
        run_cycles(CNT_MOD + 4);
        CLR_CNT = 1'b1; do_cycle();
        CLR_CNT = 1'b0; run_cycles(2);

        // Asynchronous reset while in instruction step
        MODE       = 2'b11;
        STEP_INSTR = 1'b1;
        run_cycles(2);
        STEP_BTN = 1'b1;
        run_cycles(3);
        SYNC = 1'b1; do_cycle();
        SYNC = 1'b0; do_cycle();
        check_val("pre_rst_istep", 64'(STATE), 64'(ST_ISTEP));
        #2;
        RESET_N = 1'b0;
        #1;
        check_val("async_rst_state", 64'(STATE),  64'(ST_HALT));
        check_val("async_rst_en",    64'(CPU_EN), 64'd0);
        model_reset();
        do_cycle();
        RESET_N  = 1'b1;
        STEP_BTN = 1'b0;
        run_cycles(4);

        // Randomized stimulus
        for (int n = 0; n < 3000; n++) begin
            RESET_N = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 39) == 0) MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) DIV_VAL = DIV_W'($urandom_range(0, 4));
            if ($urandom_range(0, 5) == 0)  STEP_BTN = ~STEP_BTN;
            if ($urandom_range(0, 19) == 0) STEP_INSTR = ~STEP_INSTR;
            if ($urandom_range(0, 29) == 0) BP_EN = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0)
                BP_ADDR = ($urandom_range(0, 1) != 0) ? {16'hC000, 16'hC000} : {16'hC000, 16'h1234};
            RESUME  = ($urandom_range(0, 9) == 0);
            CLR_CNT = ($urandom_range(0, 99) == 0);
            SYNC    = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       ADDR = BP_ADDR[0 +: ADDR_W];
                1:       ADDR = BP_ADDR[ADDR_W +: ADDR_W];
                default: ADDR = 16'($urandom_range(0, 65535));
            endcase
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
